icache_dm: RTL and testbench

Direct-mapped, read-only L1 instruction cache between the instruction fetch pipeline's I-mem port (upstream consumer) and the memory bus (downstream). It accepts one fetch address at a time and returns the aligned 64-bit word containing it. Hits return on the next cycle. Misses refill a whole line by burst from memory, then return the word. A single-cycle invalidate supports `fence.i`.

---
 rtl/icache_dm.sv | 248 ++++++++++++++++++++++++
 tb/tb_icache_dm.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only L1 instruction cache.
//
// Sits between the fetch pipeline's I-mem port and the memory bus. One fetch
// is in flight at a time; the aligned 64-bit word containing the fetch address
// is returned one cycle after the request on a hit, or after a full-line burst
// refill on a miss. A single-cycle invalidate clears every valid bit (fence.i).
//
// Ports:
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   im_req_addr      fetch address, bits [2:0] ignored
//   im_req_valid     single-cycle request strobe (no ready; one outstanding)
//   im_resp_rdata    aligned word for the request
//   im_resp_valid    one-cycle response pulse
//   invalidate       clears all valid bits at the next edge
//   mem_req_addr     line base address of the refill
//   mem_req_valid    refill request, held until mem_req_ready
//   mem_req_ready    refill request accepted
//   mem_resp_rdata   refill beat data
//   mem_resp_valid   one refill beat (LINE_WORDS beats, ascending order)
module icache_dm #(
  parameter int unsigned LINE_WORDS  = 4,
  parameter int unsigned SETS        = 64,
  parameter bit          RESET_VALID = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] im_req_addr,
  input  logic        im_req_valid,
  output logic [63:0] im_resp_rdata,
  output logic        im_resp_valid,
  input  logic        invalidate,
  output logic [63:0] mem_req_addr,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  input  logic [63:0] mem_resp_rdata,
  input  logic        mem_resp_valid
);

  localparam int unsigned WORD_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned OFF    = 3 + WORD_W;
  localparam int unsigned TAG_W  = 64 - OFF - IDX_W;
  localparam int unsigned RAM_AW = IDX_W + WORD_W;
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOOKUP   = 3'd1,
    ST_MISS_REQ = 3'd2,
    ST_REFILL   = 3'd3,
    ST_RESP     = 3'd4
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [63:3]         req_addr_r;
  logic [TAG_W-1:0]    tag_mem_r [0:SETS-1];
  logic [63:0]         data_mem_r [0:SETS*LINE_WORDS-1];
  logic [TAG_W-1:0]    tag_rd_r;
  logic [63:0]         data_rd_r;
  logic [SETS-1:0]     valid_r;
  logic [WORD_W-1:0]   beat_cnt_r;
  logic [63:0]         crit_word_r;
  logic                inv_pend_r;

  logic [WORD_W-1:0]   req_word_s;
  logic [IDX_W-1:0]    req_idx_s;
  logic [TAG_W-1:0]    req_tag_s;
  logic [WORD_W-1:0]   new_word_s;
  logic [IDX_W-1:0]    new_idx_s;
  logic [RAM_AW-1:0]   new_ram_addr_s;
  logic [RAM_AW-1:0]   fill_ram_addr_s;
  logic                hit_s;
  logic                accept_s;
  logic                beat_s;
  logic                last_beat_s;
  logic                unused_addr_bits_s;

  // Byte offset within the word carries no information for a 64-bit fetch.
  assign unused_addr_bits_s = ^im_req_addr[2:0];

  assign req_word_s      = req_addr_r[OFF-1:3];
  assign req_idx_s       = req_addr_r[OFF+IDX_W-1:OFF];
  assign req_tag_s       = req_addr_r[63:OFF+IDX_W];
  assign new_word_s      = im_req_addr[OFF-1:3];
  assign new_idx_s       = im_req_addr[OFF+IDX_W-1:OFF];
  assign new_ram_addr_s  = {new_idx_s, new_word_s};
  assign fill_ram_addr_s = {req_idx_s, beat_cnt_r};
  assign beat_s          = (state_r == ST_REFILL) && mem_resp_valid;
  assign last_beat_s     = beat_s && (beat_cnt_r == LAST_BEAT);

  // Hit detect and request acceptance; a new request is taken in IDLE and in
  // any cycle that is already delivering a response (LOOKUP hit or RESP).
  always_comb begin
    hit_s    = 1'b0;
    accept_s = 1'b0;
    if (valid_r[req_idx_s] && (tag_rd_r == req_tag_s)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
    case (state_r)
      ST_IDLE:   accept_s = im_req_valid;
      ST_LOOKUP: accept_s = im_req_valid && hit_s;
      ST_RESP:   accept_s = im_req_valid;
      default:   accept_s = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (im_req_valid) state_s = ST_LOOKUP;
        else              state_s = ST_IDLE;
      end
      ST_LOOKUP: begin
        if (!hit_s)            state_s = ST_MISS_REQ;
        else if (im_req_valid) state_s = ST_LOOKUP;
        else                   state_s = ST_IDLE;
      end
      ST_MISS_REQ: begin
        if (mem_req_ready) state_s = ST_REFILL;
        else               state_s = ST_MISS_REQ;
      end
      ST_REFILL: begin
        if (last_beat_s) state_s = ST_RESP;
        else             state_s = ST_REFILL;
      end
      ST_RESP: begin
        if (im_req_valid) state_s = ST_LOOKUP;
        else              state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM outputs; everything decodes from the state register except the hit
  // response, which must appear the cycle after the synchronous RAM read.
  always_comb begin
    im_resp_valid = 1'b0;
    im_resp_rdata = 64'd0;
    mem_req_valid = 1'b0;
    mem_req_addr  = 64'd0;
    case (state_r)
      ST_LOOKUP: begin
        im_resp_valid = hit_s;
        im_resp_rdata = data_rd_r;
      end
      ST_MISS_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_addr_r[63:OFF], {OFF{1'b0}}};
      end
      ST_RESP: begin
        im_resp_valid = 1'b1;
        im_resp_rdata = crit_word_r;
      end
      default: begin
        im_resp_valid = 1'b0;
        im_resp_rdata = 64'd0;
      end
    endcase
  end

  // Latch the accepted fetch address for the whole transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr_r <= '0;
    end else if (accept_s) begin
      req_addr_r <= im_req_addr[63:3];
    end
  end

  // Tag and data arrays: written by the refill, no reset (valid bits guard them).
  always_ff @(posedge clk) begin
    if (beat_s) begin
      data_mem_r[fill_ram_addr_s] <= mem_resp_rdata;
    end
    if (last_beat_s) begin
      tag_mem_r[req_idx_s] <= req_tag_s;
    end
  end

  // Synchronous read port, launched on request acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_rd_r  <= '0;
      data_rd_r <= '0;
    end else if (accept_s) begin
      tag_rd_r  <= tag_mem_r[new_idx_s];
      data_rd_r <= data_mem_r[new_ram_addr_s];
    end
  end

  // Refill beat counter; wraps to zero after the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_r <= '0;
    end else if (state_r == ST_MISS_REQ) begin
      beat_cnt_r <= '0;
    end else if (beat_s) begin
      beat_cnt_r <= beat_cnt_r + WORD_W'(1'b1);
    end
  end

  // Capture the requested word as it streams past.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crit_word_r <= 64'd0;
    end else if (beat_s && (beat_cnt_r == req_word_s)) begin
      crit_word_r <= mem_resp_rdata;
    end
  end

  // Remembers an invalidate seen while a refill is in progress, so the stale
  // line is not marked valid when it completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_pend_r <= 1'b0;
    end else if (state_r == ST_LOOKUP) begin
      inv_pend_r <= 1'b0;
    end else if (invalidate && ((state_r == ST_MISS_REQ) || (state_r == ST_REFILL))) begin
      inv_pend_r <= 1'b1;
    end
  end

  // Valid bits; a same-cycle invalidate beats the refill-complete set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= {SETS{RESET_VALID}};
    end else if (invalidate) begin
      valid_r <= '0;
    end else if (last_beat_s && !inv_pend_r) begin
      valid_r[req_idx_s] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed self-checking bench for icache_dm.
// A line-level model (valid/tag per set, memory word = function of address)
// predicts hit or miss per request; expected responses go into a queue keyed
// by cycle and a single negedge process compares every cycle.
module tb_icache_dm;
  localparam int LW = 4;
  localparam int NS = 64;

  logic        clk;
  logic        rst_n;
  logic [63:0] im_req_addr;
  logic        im_req_valid;
  logic [63:0] im_resp_rdata;
  logic        im_resp_valid;
  logic        invalidate;
  logic [63:0] mem_req_addr;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_resp_rdata;
  logic        mem_resp_valid;
  logic        inv_stim;
  logic        inv_mem;

  assign invalidate = inv_stim | inv_mem;

  icache_dm #(.LINE_WORDS(LW), .SETS(NS), .RESET_VALID(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .im_req_addr(im_req_addr), .im_req_valid(im_req_valid),
    .im_resp_rdata(im_resp_rdata), .im_resp_valid(im_resp_valid),
    .invalidate(invalidate),
    .mem_req_addr(mem_req_addr), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_resp_rdata(mem_resp_rdata), .mem_resp_valid(mem_resp_valid)
  );

  typedef struct { int cyc; logic [63:0] data; } exp_t;
  exp_t        exp_q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          resp_seen = 0;
  int          last_beat_cyc = 0;
  int          n_mem_req = 0;
  bit          model_valid [NS];
  logic [63:0] model_tag [NS];
  bit          miss_pending = 1'b0;
  logic [63:0] miss_addr = 64'd0;
  int          rdy_dly = 0;
  int          beat_gap = 0;
  int          inv_beat = -1;
  bit          exp_now;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
  endfunction

  function automatic int set_of(input logic [63:0] a);
    return int'((a / 64'(LW * 8)) % 64'(NS));
  endfunction

  function automatic logic [63:0] tag_of(input logic [63:0] a);
    return a / 64'(LW * 8 * NS);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    foreach (model_valid[i]) model_valid[i] = 1'b0;
  endtask

  // Per-cycle compare against the model's expectations.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_resp_valid", 64'(im_resp_valid), 64'd0);
        check("reset_mem_req_valid", 64'(mem_req_valid), 64'd0);
        check("reset_data_addr", im_resp_rdata | mem_req_addr, 64'd0);
      end else begin
        exp_now = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        check("resp_valid", 64'(im_resp_valid), 64'(exp_now));
        if (exp_now) begin
          if (im_resp_valid) check("resp_rdata", im_resp_rdata, exp_q[0].data);
          void'(exp_q.pop_front());
        end
        if (im_resp_valid) resp_seen++;
        if (!miss_pending) check("no_mem_req", 64'(mem_req_valid), 64'd0);
        if (invalidate) model_clear();
      end
    end
  end

  // Memory side: one step is one cycle, acting just after the rising edge.
  task automatic mstep(output bit aborted);
    @(posedge clk);
    #1;
    aborted = !rst_n;
  endtask

  task automatic mem_idle();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    inv_mem        = 1'b0;
  endtask

  task automatic serve();
    logic [63:0] a;
    logic [63:0] base;
    bit          killed;
    bit          ab;
    n_mem_req++;
    a      = miss_addr;
    base   = (a / 64'(LW * 8)) * 64'(LW * 8);
    killed = 1'b0;
    check("mem_req_addr", mem_req_addr, base);
    for (int d = 0; d < rdy_dly; d++) begin
      mstep(ab);
      if (ab) begin mem_idle(); miss_pending = 1'b0; return; end
      check("mem_req_stable", mem_req_valid ? mem_req_addr : 64'hDEAD_DEAD, base);
    end
    mem_req_ready = 1'b1;
    mstep(ab);
    mem_req_ready = 1'b0;
    if (ab) begin mem_idle(); miss_pending = 1'b0; return; end
    for (int k = 0; k < LW; k++) begin
      mem_resp_valid = 1'b1;
      mem_resp_rdata = mem_word(base + 64'(8 * k));
      inv_mem        = (k == inv_beat);
      if (k == inv_beat) killed = 1'b1;
      if (k == LW - 1) begin
        last_beat_cyc = cyc;
        exp_q.push_back('{cyc + 1, mem_word({a[63:3], 3'b000})});
        if (!killed) begin
          model_valid[set_of(a)] = 1'b1;
          model_tag[set_of(a)]   = tag_of(a);
        end
        miss_pending = 1'b0;
      end
      mstep(ab);
      mem_resp_valid = 1'b0;
      inv_mem        = 1'b0;
      if (ab) begin mem_idle(); miss_pending = 1'b0; return; end
      for (int g = 0; g < beat_gap; g++) begin
        mstep(ab);
        if (ab) begin mem_idle(); miss_pending = 1'b0; return; end
      end
    end
  endtask

  initial begin
    mem_idle();
    mem_resp_rdata = 64'd0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && mem_req_valid) serve();
    end
  end

  // Stimulus helpers.
  task automatic tick();
    @(posedge clk);
    #1;
    im_req_valid = 1'b0;
    inv_stim     = 1'b0;
  endtask

  task automatic issue(input logic [63:0] a);
    int s;
    s = set_of(a);
    im_req_valid = 1'b1;
    im_req_addr  = a;
    if (model_valid[s] && (model_tag[s] == tag_of(a))) begin
      exp_q.push_back('{cyc + 1, mem_word({a[63:3], 3'b000})});
    end else begin
      miss_pending = 1'b1;
      miss_addr    = a;
    end
  endtask

  task automatic wait_resp(output int rc);
    int n;
    n = 0;
    while (!im_resp_valid && n < 100) begin
      tick();
      n++;
    end
    n_cmp++;
    if (!im_resp_valid) begin
      n_fail++;
      $display("FAIL wait_resp: no response within 100 cycles, required one (cycle %0d)", cyc);
    end
    rc = cyc;
  endtask

  task automatic reset_model();
    model_clear();
    exp_q.delete();
    miss_pending = 1'b0;
  endtask

  initial begin
    int t0;
    int rc;
    int rc2;
    int m0;
    int rs0;
    rst_n        = 1'b1;
    im_req_valid = 1'b0;
    im_req_addr  = 64'd0;
    inv_stim     = 1'b0;
    model_clear();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_resp_valid", 64'(im_resp_valid), 64'd0);
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_mem_req_addr", mem_req_addr, 64'd0);
    check("rst_resp_rdata", im_resp_rdata, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Cold miss with zero-wait memory.
    tick();
    t0 = cyc;
    issue(64'h0000_0000_1000_0000);
    tick();
    tick();
    check("cold_mem_req_valid", 64'(mem_req_valid), 64'd1);
    check("cold_mem_req_addr", mem_req_addr, 64'h0000_0000_1000_0000);
    wait_resp(rc);
    check("cold_latency", 64'(rc), 64'(t0 + 7));
    check("cold_data", im_resp_rdata, 64'hB5A5_0000_EFFF_FFFF);

    // Re-request inside the line: hit next cycle, no memory traffic.
    tick();
    t0 = cyc;
    m0 = n_mem_req;
    issue(64'h0000_0000_1000_0004);
    tick();
    wait_resp(rc);
    check("hit_latency", 64'(rc), 64'(t0 + 1));
    check("hit_data", im_resp_rdata, 64'hB5A5_0000_EFFF_FFFF);
    check("hit_no_refill", 64'(n_mem_req - m0), 64'd0);

    // Streaming hits, one request per response cycle.
    tick();
    rs0 = resp_seen;
    issue(64'h0000_0000_1000_0000); tick();
    issue(64'h0000_0000_1000_0008); tick();
    issue(64'h0000_0000_1000_0010); tick();
    issue(64'h0000_0000_1000_0018); tick();
    tick();
    check("stream_count", 64'(resp_seen - rs0), 64'd4);

    // Invalidate during a LOOKUP hit: hit still returned, next access misses.
    tick();
    t0 = cyc;
    m0 = n_mem_req;
    issue(64'h0000_0000_1000_0008);
    tick();
    inv_stim = 1'b1;
    wait_resp(rc);
    check("inv_hit_latency", 64'(rc), 64'(t0 + 1));
    tick();
    tick();
    issue(64'h0000_0000_1000_0008);
    tick();
    wait_resp(rc);
    check("inv_then_miss", 64'(n_mem_req - m0), 64'd1);

    // Conflict: same index, different tag evicts the line.
    tick();
    m0 = n_mem_req;
    issue(64'h0000_0000_1000_0800);
    tick();
    wait_resp(rc);
    tick();
    issue(64'h0000_0000_1000_0000);
    tick();
    wait_resp(rc);
    check("conflict_refills", 64'(n_mem_req - m0), 64'd2);

    // Critical word with gapped beats; then a hit accepted in the RESP cycle.
    tick();
    inv_stim = 1'b1;
    tick();
    beat_gap = 1;
    issue(64'h0000_0000_1000_0018);
    tick();
    wait_resp(rc);
    check("crit_after_last_beat", 64'(rc), 64'(last_beat_cyc + 1));
    check("crit_data", im_resp_rdata, 64'hB5A5_0018_EFFF_FFE7);
    issue(64'h0000_0000_1000_0010);
    tick();
    wait_resp(rc2);
    check("resp_accept_hit", 64'(rc2), 64'(rc + 1));
    beat_gap = 0;

    // Invalidate during REFILL: response delivered, line stays invalid.
    tick();
    m0 = n_mem_req;
    inv_beat = 1;
    issue(64'h0000_0000_1000_0100);
    tick();
    wait_resp(rc);
    inv_beat = -1;
    tick();
    issue(64'h0000_0000_1000_0100);
    tick();
    wait_resp(rc);
    check("inv_refill_remiss", 64'(n_mem_req - m0), 64'd2);

    // Asynchronous reset in the middle of a refill.
    tick();
    beat_gap = 1;
    issue(64'h0000_0000_1000_0040);
    repeat (5) tick();
    #3;
    rst_n = 1'b0;
    reset_model();
    #1;
    check("rst_refill_resp_valid", 64'(im_resp_valid), 64'd0);
    check("rst_refill_mem_req_valid", 64'(mem_req_valid), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    beat_gap = 0;
    tick();
    m0 = n_mem_req;
    issue(64'h0000_0000_1000_0040);
    tick();
    wait_resp(rc);
    check("rst_refill_remiss", 64'(n_mem_req - m0), 64'd1);

    // Asynchronous reset while the memory request is outstanding.
    tick();
    rdy_dly = 4;
    issue(64'h0000_0000_1000_0080);
    repeat (3) tick();
    check("missreq_valid_before_rst", 64'(mem_req_valid), 64'd1);
    check("missreq_addr_before_rst", mem_req_addr, 64'h0000_0000_1000_0080);
    #3;
    rst_n = 1'b0;
    reset_model();
    #1;
    check("rst_missreq_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_missreq_mem_req_addr", mem_req_addr, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    rdy_dly = 0;
    tick();
    m0 = n_mem_req;
    issue(64'h0000_0000_1000_0080);
    tick();
    wait_resp(rc);
    check("rst_missreq_remiss", 64'(n_mem_req - m0), 64'd1);

    repeat (3) tick();
    check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
